vga_scanout: RTL and testbench

Parametrised VGA scan-out engine, the successor to the fixed 640x480 raster-to-pins path. It generates programmable horizontal and vertical timing with configurable sync polarity. It issues pixel requests ahead of the beam to a pixel source with latency PIPE, and it can substitute built-in test patterns. All colour, sync and DE outputs are registered and aligned. It sits between the renderer/framebuffer reader and the board pin wrapper.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_timing.sv | 68 ++++++
 rtl/vga_scanout.sv | 199 +++++++++++++++++++
 tb/tb_vga_scanout.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scan-out engine: pattern modes, default
// 640x480@60 timing and helpers for counter totals and widths.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BLACK = 2'd3
  } mode_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int total4(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction

  function automatic int cnt_width(input int total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters for the scan-out engine: h/v position plus active, sync
// and frame-start flags, all belonging to the counter stage.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = total4(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = total4(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int XW      = cnt_width(H_TOTAL),
  localparam int YW      = cnt_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic [XW-1:0] h,
  output logic [YW-1:0] v,
  output logic          active,
  output logic          hsync_act,
  output logic          vsync_act,
  output logic          frame_start,
  output logic          line_end
);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_timing: every porch and sync width must be at least 1");
  end

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  // Disabling parks the beam at (0,0) so re-enable starts a clean frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (!enable) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_comb begin
    line_end    = (h == H_LAST);
    active      = enable && (h < H_ACT) && (v < V_ACT);
    hsync_act   = enable && (h >= HS_START) && (h < HS_END);
    vsync_act   = enable && (v >= VS_START) && (v < VS_END);
    frame_start = enable && (h == '0) && (v == '0);
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out engine: requests pixels ahead of the beam, generates test
// patterns, and aligns colour/sync/DE through a PIPE-deep delay line.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter int HSYNC_NEG    = 1,
  parameter int VSYNC_NEG    = 1,
  parameter int COLOR_BITS   = 4,
  parameter int PIPE         = 2,
  parameter int REVERSE_BITS = 0,
  localparam int XW = cnt_width(total4(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  localparam int YW = cnt_width(total4(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_enable,
  input  logic [1:0]            io_mode,
  output logic                  io_req,
  output logic [XW-1:0]         io_req_x,
  output logic [YW-1:0]         io_req_y,
  input  logic [COLOR_BITS-1:0] io_pix_r,
  input  logic [COLOR_BITS-1:0] io_pix_g,
  input  logic [COLOR_BITS-1:0] io_pix_b,
  output logic [COLOR_BITS-1:0] io_vga_r,
  output logic [COLOR_BITS-1:0] io_vga_g,
  output logic [COLOR_BITS-1:0] io_vga_b,
  output logic                  io_vga_hsync,
  output logic                  io_vga_vsync,
  output logic                  io_de,
  output logic                  io_frame_start
);

  if (H_ACTIVE % 8 != 0) begin : g_bad_hact
    $error("vga_scanout: H_ACTIVE must be a multiple of 8");
  end
  if (PIPE < 0 || PIPE > 4) begin : g_bad_pipe
    $error("vga_scanout: PIPE must be in 0..4");
  end

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = cnt_width(BAR_W);
  localparam int CB    = COLOR_BITS;
  localparam int SW    = 5 + 3 * CB;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  localparam logic HS_POL = (HSYNC_NEG != 0);
  localparam logic VS_POL = (VSYNC_NEG != 0);

  logic [XW-1:0] s0_h;
  logic [YW-1:0] s0_v;
  logic          s0_active, s0_hs, s0_vs, s0_fs, s0_line_end;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clock),
    .rst        (reset),
    .enable     (io_enable),
    .h          (s0_h),
    .v          (s0_v),
    .active     (s0_active),
    .hsync_act  (s0_hs),
    .vsync_act  (s0_vs),
    .frame_start(s0_fs),
    .line_end   (s0_line_end)
  );

  assign io_req   = s0_active;
  assign io_req_x = s0_h;
  assign io_req_y = s0_v;

  // Bar counter tracks the current h so bar_idx is valid in the same S0 cycle.
  logic [BW-1:0] bar_pix;
  logic [2:0]    bar_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (s0_line_end || !io_enable) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (bar_pix == BAR_LAST) begin
      bar_pix <= '0;
      bar_idx <= bar_idx + 1'b1;
    end else begin
      bar_pix <= bar_pix + 1'b1;
    end
  end

  // The frame's first pixel already uses the newly sampled mode.
  mode_t mode_q, mode_cur;
  logic  frame_first;

  assign frame_first = (s0_h == '0) && (s0_v == '0);
  assign mode_cur    = frame_first ? mode_t'(io_mode) : mode_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) mode_q <= MODE_EXT;
    else       mode_q <= mode_cur;
  end

  logic [CB-1:0] pat_r, pat_g, pat_b;
  logic          x3, y3;

  // Masking with 8 keeps narrow counters (fewer than 4 bits) legal.
  assign x3 = |(s0_h & XW'(8));
  assign y3 = |(s0_v & YW'(8));

  always_comb begin
    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    case (mode_cur)
      MODE_BARS: begin
        pat_r = {CB{bar_idx[2]}};
        pat_g = {CB{bar_idx[1]}};
        pat_b = {CB{bar_idx[0]}};
      end
      MODE_CHECK: begin
        pat_r = {CB{x3 ^ y3}};
        pat_g = {CB{x3 ^ y3}};
        pat_b = {CB{x3 ^ y3}};
      end
      default: ;
    endcase
  end

  logic [SW-1:0] s0_word, tap;

  assign s0_word = {s0_active, s0_hs, s0_vs, s0_fs, (mode_cur == MODE_EXT), pat_r, pat_g, pat_b};

  if (PIPE == 0) begin : g_nodly
    assign tap = s0_word;
  end else begin : g_dly
    logic [SW-1:0] sr [PIPE];
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < PIPE; i++) sr[i] <= '0;
      end else begin
        sr[0] <= s0_word;
        for (int i = 1; i < PIPE; i++) sr[i] <= sr[i-1];
      end
    end
    assign tap = sr[PIPE-1];
  end

  logic          t_de, t_hs, t_vs, t_fs, t_ext;
  logic [CB-1:0] t_r, t_g, t_b;
  logic [CB-1:0] col_r, col_g, col_b;

  assign {t_de, t_hs, t_vs, t_fs, t_ext, t_r, t_g, t_b} = tap;

  always_comb begin
    col_r = '0;
    col_g = '0;
    col_b = '0;
    if (t_de) begin
      col_r = t_ext ? io_pix_r : t_r;
      col_g = t_ext ? io_pix_g : t_g;
      col_b = t_ext ? io_pix_b : t_b;
    end
  end

  function automatic logic [CB-1:0] pin_order(input logic [CB-1:0] c);
    logic [CB-1:0] o;
    for (int i = 0; i < CB; i++) o[i] = (REVERSE_BITS != 0) ? c[CB-1-i] : c[i];
    return o;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_vga_r       <= '0;
      io_vga_g       <= '0;
      io_vga_b       <= '0;
      io_vga_hsync   <= HS_POL;
      io_vga_vsync   <= VS_POL;
      io_de          <= 1'b0;
      io_frame_start <= 1'b0;
    end else begin
      io_vga_r       <= pin_order(col_r);
      io_vga_g       <= pin_order(col_g);
      io_vga_b       <= pin_order(col_b);
      io_vga_hsync   <= t_hs ^ HS_POL;
      io_vga_vsync   <= t_vs ^ VS_POL;
      io_de          <= t_de;
      io_frame_start <= t_fs;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken 24x24 raster (PIPE=2) plus a
// PIPE=0 bit-reversed instance.
module tb_vga_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       enable;
  logic [1:0] io_mode;

  // Instance A: 16x18 active, 24x24 total, PIPE=2, active-low syncs.
  logic       req_a, hs_a, vs_a, de_a, fs_a;
  logic [4:0] req_x_a, req_y_a;
  logic [3:0] pix_r_a, pix_g_a, pix_b_a;
  logic [3:0] r_a, g_a, b_a;

  // Pixel source with two cycles of latency: r = x[3:0], g = y[3:0], b = r^g.
  logic [3:0] sx1, sx2, sy1, sy2;
  always @(posedge clk) begin
    sx1 <= req_x_a[3:0];
    sx2 <= sx1;
    sy1 <= req_y_a[3:0];
    sy2 <= sy1;
  end
  assign pix_r_a = sx2;
  assign pix_g_a = sy2;
  assign pix_b_a = sx2 ^ sy2;

  vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(18), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HSYNC_NEG(1), .VSYNC_NEG(1), .COLOR_BITS(4), .PIPE(2), .REVERSE_BITS(0)
  ) dut_a (
    .clock(clk), .reset(reset), .io_enable(enable), .io_mode(io_mode),
    .io_req(req_a), .io_req_x(req_x_a), .io_req_y(req_y_a),
    .io_pix_r(pix_r_a), .io_pix_g(pix_g_a), .io_pix_b(pix_b_a),
    .io_vga_r(r_a), .io_vga_g(g_a), .io_vga_b(b_a),
    .io_vga_hsync(hs_a), .io_vga_vsync(vs_a), .io_de(de_a), .io_frame_start(fs_a)
  );

  // Instance B: same raster, PIPE=0, channels bit-reversed at the pins.
  logic       enable_b = 1'b1;
  logic [1:0] mode_b = 2'd0;
  logic       req_b, hs_b, vs_b, de_b, fs_b;
  logic [4:0] req_x_b, req_y_b;
  logic [3:0] pix_r_b = 4'b0001;
  logic [3:0] pix_g_b = 4'b0011;
  logic [3:0] pix_b_b = 4'b0111;
  logic [3:0] r_b, g_b, b_b;

  vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(18), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HSYNC_NEG(1), .VSYNC_NEG(1), .COLOR_BITS(4), .PIPE(0), .REVERSE_BITS(1)
  ) dut_b (
    .clock(clk), .reset(reset), .io_enable(enable_b), .io_mode(mode_b),
    .io_req(req_b), .io_req_x(req_x_b), .io_req_y(req_y_b),
    .io_pix_r(pix_r_b), .io_pix_g(pix_g_b), .io_pix_b(pix_b_b),
    .io_vga_r(r_b), .io_vga_g(g_b), .io_vga_b(b_b),
    .io_vga_hsync(hs_b), .io_vga_vsync(vs_b), .io_de(de_b), .io_frame_start(fs_b)
  );

  int tests = 0;
  int fails = 0;
  int px = 0;
  int py = 0;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s pin=(%0d,%0d) observed=%0h expected=%0h", tag, px, py, observed, expected);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int m, input int x, input int y);
    logic [3:0] r, g, b;
    int idx;
    r = 4'h0;
    g = 4'h0;
    b = 4'h0;
    idx = x / 2;
    if (x < 16 && y < 18) begin
      case (m)
        0: begin r = x[3:0]; g = y[3:0]; b = x[3:0] ^ y[3:0]; end
        1: begin r = {4{idx[2]}}; g = {4{idx[1]}}; b = {4{idx[0]}}; end
        2: begin r = {4{x[3] ^ y[3]}}; g = r; b = r; end
        default: ;
      endcase
    end
    return {r, g, b};
  endfunction

  // Walks n pin cycles starting at (px,py), checking every output of dut_a.
  task automatic run_pins(input int n, input int m, input int set_at, input logic [1:0] new_mode);
    for (int i = 0; i < n; i++) begin
      if (i == set_at) io_mode = new_mode;
      @(negedge clk);
      chk("de", de_a, (px < 16 && py < 18));
      chk("hsync", hs_a, !(px >= 18 && px < 21));
      chk("vsync", vs_a, !(py >= 20 && py < 22));
      chk("frame_start", fs_a, (px == 0 && py == 0));
      chk("rgb", {r_a, g_a, b_a}, exp_rgb(m, px, py));
      px++;
      if (px == 24) begin
        px = 0;
        py = (py == 23) ? 0 : py + 1;
      end
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_rgb"}, {r_a, g_a, b_a}, 12'h000);
    chk({tag, "_de"}, de_a, 1'b0);
    chk({tag, "_hsync"}, hs_a, 1'b1);
    chk({tag, "_vsync"}, vs_a, 1'b1);
    chk({tag, "_fs"}, fs_a, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    io_mode = 2'd0;
    repeat (3) @(negedge clk);
    chk_blank("por");

    reset = 1'b0;
    #1;
    chk("rel_req", req_a, 1'b1);
    chk("rel_req_xy", {req_x_a, req_y_a}, 10'd0);
    @(negedge clk);
    chk("lat1_de", de_a, 1'b0);
    chk("rev_r", r_b, 4'b1000);
    chk("rev_g", g_b, 4'b1100);
    chk("rev_b", b_b, 4'b1110);
    chk("rev_de", de_b, 1'b1);
    chk("rev_fs", fs_b, 1'b1);
    @(negedge clk);
    chk("lat2_de", de_a, 1'b0);
    px = 0;
    py = 0;
    run_pins(8, 0, -1, 2'd0);

    // Reset mid-line: pins must clear without waiting for a clock.
    reset = 1'b1;
    #1;
    chk_blank("rst_mid");
    chk("rst_mid_rev_de", de_b, 1'b0);
    chk("rst_mid_rev_r", r_b, 4'b0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel2_req", req_a, 1'b1);
    chk("rel2_req_xy", {req_x_a, req_y_a}, 10'd0);
    @(negedge clk);
    chk("rel2_lat1_de", de_a, 1'b0);
    chk("rel2_lat1_fs", fs_a, 1'b0);
    @(negedge clk);
    chk("rel2_lat2_de", de_a, 1'b0);
    chk("rel2_lat2_fs", fs_a, 1'b0);
    px = 0;
    py = 0;

    // Four full frames; each mode change lands mid-frame and must wait.
    run_pins(576, 0, 216, 2'd1);
    run_pins(576, 1, 216, 2'd2);
    run_pins(576, 2, 216, 2'd3);
    run_pins(576, 3, 216, 2'd0);

    // Drop enable with pin (4,2) showing; two in-flight pixels still drain.
    run_pins(53, 0, -1, 2'd0);
    enable = 1'b0;
    #1;
    chk("dis_req", req_a, 1'b0);
    run_pins(2, 0, -1, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_blank("dis");
      chk("dis_req_hold", req_a, 1'b0);
    end

    enable = 1'b1;
    #1;
    chk("reen_req", req_a, 1'b1);
    chk("reen_req_xy", {req_x_a, req_y_a}, 10'd0);
    @(negedge clk);
    chk("reen_lat1_fs", fs_a, 1'b0);
    chk("reen_lat1_de", de_a, 1'b0);
    @(negedge clk);
    chk("reen_lat2_fs", fs_a, 1'b0);
    chk("reen_lat2_de", de_a, 1'b0);
    px = 0;
    py = 0;
    run_pins(48, 0, -1, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
